// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer, valid/ready flow control and synchronous flush.
// Optional stall counter output enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] DMaddr_i,
  input  logic [DATA_W-1:0] DMdata_i,
  input  logic [RD_W-1:0]   RDaddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
`ifdef EX_MEM_PERF_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] DMaddr_o,
  output logic [DATA_W-1:0] DMdata_o,
  output logic [RD_W-1:0]   RDaddr_o
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } pay_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, nxt;
  pay_t   main_q, skid_q, in_p;
  logic   main_valid, skid_valid, accept, drain;
  logic   ld_main_in, ld_main_skid, ld_skid;

  assign in_p       = '{wb: WB_i, m: M_i, addr: DMaddr_i, data: DMdata_i, rd: RDaddr_i};
  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign in_ready_o = !skid_valid;
  assign accept     = in_valid_i & in_ready_o;
  assign drain      = main_valid & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= EMPTY;
    else          state <= nxt;
  end

  always_comb begin
    nxt          = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        ld_main_in = 1'b1;
        nxt        = ONE;
      end
      ONE: begin
        if (accept && drain) ld_main_in = 1'b1;
        else if (accept) begin
          ld_skid = 1'b1;
          nxt     = FULL;
        end else if (drain) nxt = EMPTY;
      end
      FULL: if (drain) begin
        ld_main_skid = 1'b1;
        nxt          = ONE;
      end
      default: nxt = EMPTY;
    endcase
    // Flush drops everything, including an entry offered this cycle.
    if (flush_i) begin
      nxt          = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_p;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_p;
    end
  end

  assign out_valid_o = main_valid;
  // Control bundles gated so bubbles never write memory or the register file.
  assign WB_o     = main_valid ? main_q.wb : '0;
  assign M_o      = main_valid ? main_q.m  : '0;
  assign DMaddr_o = main_q.addr;
  assign DMdata_o = main_q.data;
  assign RDaddr_o = main_q.rd;

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                                 stall_cnt_o <= '0;
    else if (flush_i)                                             stall_cnt_o <= '0;
    else if (main_valid && !out_ready_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a 2-deep FIFO reference model.
module tb_ex_mem_stage;
  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } ent_t;

  logic        clk_i = 1'b0, rst_n_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [1:0]  WB_i, M_i, WB_o, M_o;
  logic [31:0] DMaddr_i, DMdata_i, DMaddr_o, DMdata_o;
  logic [4:0]  RDaddr_i, RDaddr_o;
`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  ex_mem_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .WB_i(WB_i), .M_i(M_i), .DMaddr_i(DMaddr_i), .DMdata_i(DMdata_i), .RDaddr_i(RDaddr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
`ifdef EX_MEM_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .WB_o(WB_o), .M_o(M_o), .DMaddr_o(DMaddr_o), .DMdata_o(DMdata_o), .RDaddr_o(RDaddr_o)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0, nerr = 0;
  ent_t q[$];
  ent_t last_head;
  int   m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit v = (q.size() > 0);
    chk("in_ready", in_ready_o, q.size() < 2);
    chk("out_valid", out_valid_o, v);
    chk("WB", WB_o, v ? q[0].wb : 2'b0);
    chk("M", M_o, v ? q[0].m : 2'b0);
    chk("DMaddr", DMaddr_o, v ? q[0].addr : last_head.addr);
    chk("DMdata", DMdata_o, v ? q[0].data : last_head.data);
    chk("RDaddr", RDaddr_o, v ? q[0].rd : last_head.rd);
`ifdef EX_MEM_PERF_EN
    chk("stall_cnt", stall_cnt_o, m_cnt);
`endif
  endtask

  function automatic void model_reset();
    q.delete();
    last_head = '0;
    m_cnt = 0;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.wb = 2'($urandom); e.m = 2'($urandom);
    e.addr = $urandom; e.data = $urandom; e.rd = 5'($urandom);
    return e;
  endfunction

  // Drive one cycle of inputs from the negedge, advance the model at the posedge, check at the next negedge.
  task automatic cyc(input bit v, input bit r, input bit f, input ent_t e);
    bit acc, drn;
    in_valid_i = v; out_ready_i = r; flush_i = f;
    WB_i = e.wb; M_i = e.m; DMaddr_i = e.addr; DMdata_i = e.data; RDaddr_i = e.rd;
    @(posedge clk_i);
    acc = v && (q.size() < 2);
    drn = r && (q.size() > 0);
    if (f) m_cnt = 0;
    else if (q.size() > 0 && !r && m_cnt != 16'hFFFF) m_cnt++;
    if (f) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_head = q[0];
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    ent_t e0, ea, eb;
    rst_n_i = 1'b0; flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    WB_i = 0; M_i = 0; DMaddr_i = 0; DMdata_i = 0; RDaddr_i = 0;
    model_reset();
    #12 check_all();
    #5 rst_n_i = 1'b1;
    @(negedge clk_i);
    check_all();

    // single entry, 1-cycle latency, then empty again
    e0 = '{wb: 2'b10, m: 2'b01, addr: 32'h100, data: 32'hDEAD, rd: 5'd3};
    cyc(1, 1, 0, e0);
    chk("lat_valid", out_valid_o, 1'b1);
    chk("lat_addr", DMaddr_o, 32'h100);
    cyc(0, 1, 0, rnd_ent());
    chk("lat_empty", out_valid_o, 1'b0);

    // streaming
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, rnd_ent());
    cyc(0, 1, 0, rnd_ent());

    // backpressure A,B then drain
    ea = rnd_ent(); eb = rnd_ent();
    cyc(1, 0, 0, ea);
    cyc(1, 0, 0, eb);
    chk("bp_full", in_ready_o, 1'b0);
    chk("bp_headA", DMdata_o, ea.data);
    cyc(0, 1, 0, rnd_ent());
    chk("bp_headB", DMdata_o, eb.data);
    cyc(0, 1, 0, rnd_ent());
    chk("bp_ready", in_ready_o, 1'b1);

    // flush in FULL with an offered entry
    cyc(1, 0, 0, rnd_ent());
    cyc(1, 0, 0, rnd_ent());
    cyc(1, 0, 1, rnd_ent());
    chk("flush_valid", out_valid_o, 1'b0);
    cyc(0, 1, 0, rnd_ent());
    chk("flush_drop", out_valid_o, 1'b0);

    // asynchronous reset while FULL
    cyc(1, 0, 0, rnd_ent());
    cyc(1, 0, 0, rnd_ent());
    #1 rst_n_i = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_all();

`ifdef EX_MEM_PERF_EN
    cyc(1, 0, 0, rnd_ent());
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, rnd_ent());
    chk("stall5", stall_cnt_o, 16'd5);
    cyc(0, 0, 1, rnd_ent());
    chk("stall_flush", stall_cnt_o, 16'd0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, rnd_ent());

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline stage register with valid/ready flow control and a 2-entry skid buffer, so backpressure from MEM never combinationally reaches EX. It carries the WB/M control bundles, the data-memory address and write data, and the destination register address. It adds a synchronous flush that squashes in-flight entries. It sits between the ALU/forwarding logic and the data-memory stage of the 5-stage CPU.

Parameters:
WB_W, 2, width of write-back control bundle
M_W, 2, width of memory control bundle
DATA_W, 32, width of DMaddr and DMdata fields
RD_W, 5, width of destination register address

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous squash of all held entries
in_valid_i  input  1  EX presents a valid entry
in_ready_o  output  1  stage can accept an entry this cycle
WB_i  input  WB_W  write-back control
M_i  input  M_W  memory control
DMaddr_i  input  DATA_W  data-memory address (ALU result)
DMdata_i  input  DATA_W  data-memory write data
RDaddr_i  input  RD_W  destination register
out_valid_o  output  1  MEM-side entry valid
out_ready_i  input  1  MEM consumes entry this cycle
WB_o  output  WB_W  registered WB control, gated
M_o  output  M_W  registered M control, gated
DMaddr_o  output  DATA_W  registered address
DMdata_o  output  DATA_W  registered write data
RDaddr_o  output  RD_W  registered destination register

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values: all valid bits 0; all payload registers 0. While reset is asserted and after it releases: out_valid_o=0, WB_o=0, M_o=0, DMaddr_o=0, DMdata_o=0, RDaddr_o=0, in_ready_o=1.
- Storage: a main register drives the outputs; a skid register holds overflow. Each has its own valid bit.
- Definitions: accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i.
- in_ready_o = !skid_valid. It is a registered-state function with no combinational path from out_ready_i.
- out_valid_o = main_valid.
- States are EMPTY (main=0, skid=0), ONE (main=1, skid=0) and FULL (main=1, skid=1).
  - EMPTY: if accept, load main from inputs and go to ONE.
  - ONE, accept & drain: load main from inputs, stay ONE.
  - ONE, accept & !drain: load skid from inputs, go to FULL.
  - ONE, !accept & drain: clear main_valid, go to EMPTY.
  - ONE, neither: hold.
  - FULL (in_ready_o=0): if drain, copy skid to main, clear skid_valid, go to ONE; otherwise hold all state.
- Latency: 1 cycle from accept in EMPTY to out_valid_o=1 with the payload.
- Ordering: strict FIFO. The skid entry always drains after the main entry.
- Flush: flush_i is synchronous and has highest priority. At the next edge both valid bits clear and the state goes to EMPTY. An entry offered in the flush cycle is dropped, even if in_ready_o=1. A drain in the flush cycle still counts as consumed by MEM.
- Gating: WB_o and M_o are forced to 0 whenever out_valid_o=0, so bubbles never write memory or the register file. DMaddr_o, DMdata_o and RDaddr_o hold their last value when invalid.
- Mid-operation reset: reset asserted in any state returns immediately, asynchronously, to the reset values.
- No arithmetic; fields pass through unmodified at their parameter widths.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits), reset to 0.
  - Increments by 1 on each cycle with out_valid_o=1 and out_ready_i=0.
  - Saturates at 16'hFFFF.
  - Cleared by flush_i.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then one entry {WB=2'b10, M=2'b01, DMaddr=32'h100, DMdata=32'hDEAD, RD=5'd3} with out_ready_i=1 -> out_valid_o=1 with identical fields exactly 1 cycle later, EMPTY again the cycle after.
2. Streaming: 8 back-to-back entries with out_ready_i=1 every cycle -> in_ready_o stays 1; outputs appear in order, one per cycle.
3. Backpressure: out_ready_i=0, offer entries A and B on consecutive cycles -> A held on outputs, B in skid, in_ready_o=0. Raise out_ready_i -> A then B delivered in order and in_ready_o returns to 1.
4. Flush in FULL state with in_valid_i=1 -> next cycle out_valid_o=0, WB_o=0, M_o=0, in_ready_o=1; the offered entry is never delivered.
5. Assert rst_n_i=0 asynchronously between clock edges while FULL -> outputs go to 0 immediately, without waiting for a clock edge.
6. With EX_MEM_PERF_EN defined: hold out_ready_i=0 for 5 cycles with a valid entry -> stall_cnt_o=5; then flush -> stall_cnt_o=0.
